// File: rtl/mecobo_pkg.sv
// ---------------------------------------------------------------------------
// mecobo_pkg
// Shared definitions for the sample sequencer and its capture buffer.
//   CH_NONE      : channel_select value meaning "no channel selected"
//   SAMPLE_W     : width of one sample bus word
//   seq_state_e  : scan FSM states (idle, channel selected/settling, capture)
// ---------------------------------------------------------------------------
package mecobo_pkg;

  localparam logic [7:0] CH_NONE  = 8'hFF;
  localparam int         SAMPLE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_CAP  = 2'd2
  } seq_state_e;

endpackage : mecobo_pkg

// File: rtl/sample_buffer.sv
// ---------------------------------------------------------------------------
// sample_buffer
// Synchronous circular FIFO holding captured sample words until the MCU pops
// them. Storage is a plain array written and read on the clock so it maps to
// block RAM; the read data register is the RAM output register.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (pointers/count cleared)
//   wr_req     in   capture request for wr_data this cycle
//   wr_data    in   word to store
//   wr_drop    out  wr_req arrived while full; word is discarded
//   rd_en      in   pop request (ignored while empty)
//   rd_data    out  popped word, registered
//   rd_valid   out  one-cycle pulse, rd_data holds a freshly popped word
//   empty      out  no entries stored (registered)
//   fill_count out  number of entries stored (registered)
// ---------------------------------------------------------------------------
module sample_buffer
  import mecobo_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_req,
  input  logic [SAMPLE_W-1:0]     wr_data,
  output logic                    wr_drop,
  input  logic                    rd_en,
  output logic [SAMPLE_W-1:0]     rd_data,
  output logic                    rd_valid,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  fill_count
);

  localparam int AW = $clog2(DEPTH);
  // One extra pointer bit so a full buffer and an empty one differ.
  localparam int PW = AW + 1;

  logic [SAMPLE_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]       wr_ptr_r;
  logic [PW-1:0]       rd_ptr_r;
  logic [PW-1:0]       fill_r;
  logic [PW-1:0]       fill_next_s;
  logic                full_s;
  logic                do_wr_s;
  logic                do_rd_s;
  logic [SAMPLE_W-1:0] rd_data_r;
  logic                rd_valid_r;
  logic                empty_r;

  // Qualify write and pop; full is judged on the count before this cycle,
  // so a pop in the same cycle does not make room for a capture.
  always_comb begin
    full_s  = (fill_r == PW'(DEPTH));
    do_wr_s = wr_req & ~full_s;
    do_rd_s = rd_en & ~empty_r;
    wr_drop = wr_req & full_s;
    case ({do_wr_s, do_rd_s})
      2'b10:   fill_next_s = fill_r + PW'(1);
      2'b01:   fill_next_s = fill_r - PW'(1);
      default: fill_next_s = fill_r;
    endcase
  end

  // RAM write port and registered read port.
  always_ff @(posedge clk) begin
    if (do_wr_s && !rst) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
    if (rst) begin
      rd_data_r <= '0;
    end else if (do_rd_s) begin
      rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
    end
  end

  // Pointers, occupancy and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fill_r     <= '0;
      empty_r    <= 1'b1;
      rd_valid_r <= 1'b0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      fill_r     <= fill_next_s;
      empty_r    <= (fill_next_s == '0);
      rd_valid_r <= do_rd_s;
    end
  end

  assign rd_data    = rd_data_r;
  assign rd_valid   = rd_valid_r;
  assign empty      = empty_r;
  assign fill_count = fill_r;

endmodule : sample_buffer

// File: rtl/sample_sequencer.sv
// ---------------------------------------------------------------------------
// sample_sequencer
// Round-robin sampling engine. While enabled it walks channel_select over the
// set bits of a mask latched at scan start, holds each channel for
// SETTLE_CYCLES cycles plus one capture cycle, and stores the sample bus word
// of every visited channel in a circular buffer that the MCU pops.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   enable         in   run request (level); checked at each channel end
//   channel_mask   in   channels to scan, latched when a scan starts
//   output_sample  out  sample strobe to the pin controllers
//   channel_select out  selected channel, CH_NONE when idle
//   sample_data    in   wired-OR sample bus from the selected controller
//   rd_en          in   pop request
//   rd_data        out  popped word
//   rd_valid       out  rd_data valid pulse
//   empty          out  buffer empty
//   fill_count     out  entries stored
//   overflow       out  sticky, a capture was dropped because buffer full
//   clear_overflow in   clears overflow (a same-cycle drop wins)
//   busy           out  scan in progress
// ---------------------------------------------------------------------------
module sample_sequencer
  import mecobo_pkg::*;
#(
  parameter int NUM_CHANNELS  = 16,
  parameter int DEPTH         = 256,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CHANNELS-1:0]  channel_mask,
  output logic                     output_sample,
  output logic [7:0]               channel_select,
  input  logic [SAMPLE_W-1:0]      sample_data,
  input  logic                     rd_en,
  output logic [SAMPLE_W-1:0]      rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill_count,
  output logic                     overflow,
  input  logic                     clear_overflow,
  output logic                     busy
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  seq_state_e              state_r;
  seq_state_e              state_next_s;
  logic [NUM_CHANNELS-1:0] mask_r;
  logic [NUM_CHANNELS-1:0] mask_next_s;
  logic [7:0]              ch_r;
  logic [7:0]              ch_next_s;
  logic [SETTLE_W-1:0]     settle_r;
  logic [SETTLE_W-1:0]     settle_next_s;
  logic                    wr_req_s;
  logic                    wr_drop_s;
  logic                    output_sample_r;
  logic                    output_sample_next_s;
  logic [7:0]              channel_select_r;
  logic [7:0]              channel_select_next_s;
  logic                    busy_r;
  logic                    overflow_r;

  // Lowest set bit of a mask; CH_NONE when the mask is zero.
  function automatic logic [7:0] lowest_set(input logic [NUM_CHANNELS-1:0] m);
    logic [7:0] r;
    r = CH_NONE;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      r = m[i] ? 8'(i) : r;
    end
    return r;
  endfunction

  // Next set bit strictly above cur, wrapping to the lowest set bit. With a
  // single-bit mask this returns cur again.
  function automatic logic [7:0] next_set(input logic [NUM_CHANNELS-1:0] m,
                                          input logic [7:0]              cur);
    logic [7:0] r;
    r = lowest_set(m);
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      r = (m[i] && (8'(i) > cur)) ? 8'(i) : r;
    end
    return r;
  endfunction

  // Scan FSM next state plus next values of the registered outputs.
  always_comb begin
    state_next_s  = state_r;
    mask_next_s   = mask_r;
    ch_next_s     = ch_r;
    settle_next_s = settle_r;
    wr_req_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable && (channel_mask != '0)) begin
          mask_next_s   = channel_mask;
          ch_next_s     = lowest_set(channel_mask);
          settle_next_s = '0;
          state_next_s  = ST_SEL;
        end else begin
          state_next_s  = ST_IDLE;
        end
      end
      ST_SEL: begin
        if (settle_r == SETTLE_LAST) begin
          state_next_s  = ST_CAP;
        end else begin
          settle_next_s = settle_r + SETTLE_W'(1);
        end
      end
      ST_CAP: begin
        // enable is only honoured here, so a channel is never cut short.
        wr_req_s      = 1'b1;
        ch_next_s     = next_set(mask_r, ch_r);
        settle_next_s = '0;
        if (enable) begin
          state_next_s = ST_SEL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase

    if (state_next_s == ST_IDLE) begin
      output_sample_next_s  = 1'b0;
      channel_select_next_s = CH_NONE;
    end else begin
      output_sample_next_s  = 1'b1;
      channel_select_next_s = ch_next_s;
    end
  end

  // FSM state, latched scan context and registered strobe/select/busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      mask_r           <= '0;
      ch_r             <= CH_NONE;
      settle_r         <= '0;
      output_sample_r  <= 1'b0;
      channel_select_r <= CH_NONE;
      busy_r           <= 1'b0;
    end else begin
      state_r          <= state_next_s;
      mask_r           <= mask_next_s;
      ch_r             <= ch_next_s;
      settle_r         <= settle_next_s;
      output_sample_r  <= output_sample_next_s;
      channel_select_r <= channel_select_next_s;
      busy_r           <= (state_next_s != ST_IDLE);
    end
  end

  // Sticky overflow; a drop in the same cycle beats a clear request.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (wr_drop_s) begin
      overflow_r <= 1'b1;
    end else if (clear_overflow) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  sample_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req_s),
    .wr_data    (sample_data),
    .wr_drop    (wr_drop_s),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .fill_count (fill_count)
  );

  assign output_sample  = output_sample_r;
  assign channel_select = channel_select_r;
  assign busy           = busy_r;
  assign overflow       = overflow_r;

endmodule : sample_sequencer

// File: tb/tb_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sample_sequencer
// Directed scenarios followed by a randomized phase. A timeline model (active
// flag, list of mask channels, cycles spent on the current channel, a word
// queue) predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_sample_sequencer;

  localparam int NCH    = 16;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;

  logic            clk;
  logic            rst;
  logic            enable;
  logic [NCH-1:0]  channel_mask;
  logic            output_sample;
  logic [7:0]      channel_select;
  logic [31:0]     sample_data;
  logic            rd_en;
  logic [31:0]     rd_data;
  logic            rd_valid;
  logic            empty;
  logic [2:0]      fill_count;
  logic            overflow;
  logic            clear_overflow;
  logic            busy;

  logic            sd_rand;
  logic [31:0]     sd_word;

  int tests;
  int fails;

  // Model state
  bit          m_active;
  int          m_chs[$];
  int          m_idx;
  int          m_age;
  logic [31:0] m_q[$];
  bit          m_ovf;
  bit          m_rdv;
  logic [31:0] m_rdd;

  sample_sequencer #(
    .NUM_CHANNELS  (NCH),
    .DEPTH         (DEPTH),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .channel_mask   (channel_mask),
    .output_sample  (output_sample),
    .channel_select (channel_select),
    .sample_data    (sample_data),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .empty          (empty),
    .fill_count     (fill_count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .busy           (busy)
  );

  // The selected controller answers with a channel-tagged word unless the
  // bench overrides the bus with a random value.
  assign sample_data = sd_rand ? sd_word : (32'hA000_0000 | {24'h0, channel_select});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    bit          full;
    bit          pop;
    bit          cap;
    logic [31:0] word;
    if (rst) begin
      m_active = 1'b0;
      m_q.delete();
      m_ovf    = 1'b0;
      m_rdv    = 1'b0;
      m_rdd    = 32'h0;
      m_idx    = 0;
      m_age    = 0;
    end else begin
      full = (m_q.size() == DEPTH);
      pop  = rd_en && (m_q.size() != 0);
      cap  = m_active && (m_age == SETTLE);
      if (pop) begin
        m_rdd = m_q.pop_front();
        m_rdv = 1'b1;
      end else begin
        m_rdv = 1'b0;
      end
      if (cap && full) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      if (cap && !full) begin
        word = sd_rand ? sd_word : (32'hA000_0000 | 32'(m_chs[m_idx]));
        m_q.push_back(word);
      end
      if (m_active) begin
        if (m_age == SETTLE) begin
          if (enable) begin
            m_idx = (m_idx + 1) % m_chs.size();
            m_age = 0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_age++;
        end
      end else if (enable && (channel_mask != '0)) begin
        m_chs.delete();
        for (int i = 0; i < NCH; i++) if (channel_mask[i]) m_chs.push_back(i);
        m_idx    = 0;
        m_age    = 0;
        m_active = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    logic [7:0] exp_cs;
    exp_cs = m_active ? 8'(m_chs[m_idx]) : 8'hFF;
    chk("busy",           32'(busy),           32'(m_active));
    chk("output_sample",  32'(output_sample),  32'(m_active));
    chk("channel_select", 32'(channel_select), 32'(exp_cs));
    chk("fill_count",     32'(fill_count),     32'(m_q.size()));
    chk("empty",          32'(empty),          32'(m_q.size() == 0));
    chk("overflow",       32'(overflow),       32'(m_ovf));
    chk("rd_valid",       32'(rd_valid),       32'(m_rdv));
    chk("rd_data",        rd_data,             m_rdd);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    int          exp_seq[10];
    logic [31:0] exp_words[4];
    logic [7:0]  rec[10];

    tests = 0;
    fails = 0;
    rst = 1'b1; enable = 1'b0; channel_mask = '0; rd_en = 1'b0;
    clear_overflow = 1'b0; sd_rand = 1'b0; sd_word = 32'h0;
    m_active = 1'b0; m_idx = 0; m_age = 0; m_ovf = 1'b0; m_rdv = 1'b0; m_rdd = 32'h0;

    // Reset state
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    chk("reset_cs",    32'(channel_select), 32'hFF);
    chk("reset_empty", 32'(empty),          32'h1);
    chk("reset_rdd",   rd_data,             32'h0);

    // Mask 0x0005 scan, overfill a 4-deep buffer, then drain in order
    exp_seq   = '{0, 0, 2, 2, 0, 0, 2, 2, 0, 0};
    exp_words = '{32'hA000_0000, 32'hA000_0002, 32'hA000_0000, 32'hA000_0002};
    channel_mask = 16'h0005;
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      rec[k] = channel_select;
    end
    enable = 1'b0;
    cycle();
    for (int k = 0; k < 10; k++) chk("t1_sel_seq", 32'(rec[k]), 32'(exp_seq[k]));
    chk("t1_overflow", 32'(overflow),       32'h1);
    chk("t1_fill",     32'(fill_count),     32'h4);
    chk("t1_idle_cs",  32'(channel_select), 32'hFF);
    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t1_pop_valid", 32'(rd_valid), 32'h1);
      chk("t1_pop_data",  rd_data,       exp_words[k]);
    end
    rd_en = 1'b0;
    cycle();
    chk("t1_drained", 32'(empty), 32'h1);
    rd_en = 1'b1;
    cycle();
    chk("t1_pop_empty", 32'(rd_valid), 32'h0);
    rd_en = 1'b0;
    clear_overflow = 1'b1;
    cycle();
    clear_overflow = 1'b0;
    chk("t1_ovf_clear", 32'(overflow), 32'h0);

    // Zero mask never starts a scan
    channel_mask = 16'h0000;
    enable = 1'b1;
    repeat (20) cycle();
    chk("t2_busy", 32'(busy),           32'h0);
    chk("t2_os",   32'(output_sample),  32'h0);
    chk("t2_cs",   32'(channel_select), 32'hFF);
    chk("t2_fill", 32'(fill_count),     32'h0);

    // Full buffer: pop and capture in the same cycle drops the capture
    channel_mask = 16'h0001;
    repeat (10) cycle();
    chk("t4_full_before", 32'(fill_count), 32'h4);
    chk("t4_ovf_before",  32'(overflow),   32'h0);
    rd_en = 1'b1;
    cycle();
    chk("t4_fill_after", 32'(fill_count), 32'h3);
    chk("t4_ovf_after",  32'(overflow),   32'h1);
    chk("t4_pop_data",   rd_data,         32'hA000_0000);
    rd_en = 1'b0;
    enable = 1'b0;
    repeat (3) cycle();
    chk("t4_idle", 32'(busy), 32'h0);
    rd_en = 1'b1;
    repeat (4) cycle();
    rd_en = 1'b0;
    clear_overflow = 1'b1;
    cycle();
    clear_overflow = 1'b0;

    // enable dropped while channel 2 is settling: it is still captured
    channel_mask = 16'h0005;
    enable = 1'b1;
    repeat (3) cycle();
    chk("t5_sel2", 32'(channel_select), 32'h2);
    enable = 1'b0;
    cycle();
    chk("t5_cap2", 32'(channel_select), 32'h2);
    cycle();
    chk("t5_idle_cs", 32'(channel_select), 32'hFF);
    chk("t5_fill",    32'(fill_count),     32'h2);
    rd_en = 1'b1;
    repeat (2) cycle();
    rd_en = 1'b0;
    chk("t5_last_word", rd_data, 32'hA000_0002);

    // Reset mid-scan with three words stored
    enable = 1'b1;
    repeat (7) cycle();
    chk("t6_fill3", 32'(fill_count), 32'h3);
    rst = 1'b1;
    cycle();
    chk("t6_empty", 32'(empty),          32'h1);
    chk("t6_fill",  32'(fill_count),     32'h0);
    chk("t6_cs",    32'(channel_select), 32'hFF);
    rst = 1'b0; enable = 1'b0; rd_en = 1'b1;
    cycle();
    chk("t6_no_valid", 32'(rd_valid), 32'h0);
    rd_en = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      rst    = ($urandom_range(0, 79) == 0);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0)
        channel_mask = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom());
      rd_en          = ($urandom_range(0, 2) == 0);
      clear_overflow = ($urandom_range(0, 15) == 0);
      sd_rand        = 1'($urandom_range(0, 1));
      sd_word        = $urandom();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sample_sequencer
